// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory port arbiter: FSM states, owner encoding
// and the read-latency counter width helper.
package mem_arb_pkg;

    typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} arb_state_t;

    typedef enum logic {OWN_CPU, OWN_LDR} arb_owner_t;

    // The counter must be able to hold values up to RD_LAT.
    function automatic int lat_cnt_w(input int rd_lat);
        return $clog2(rd_lat + 1);
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: a lone request wins outright, and on a tie the
// port that did not own the previous access wins.
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic [1:0]  req,
    input  arb_owner_t  last_owner,
    output logic [1:0]  gnt
);

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = (last_owner == OWN_LDR) ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port unified memory between the CPU controller and the
// loader/debug port, sequencing write and fixed-latency read strobes.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 13,
    parameter int RD_LAT = 2
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              ldr_req,
    input  logic              cpu_we,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic              cpu_gnt,
    output logic              ldr_gnt,
    output logic              cpu_done,
    output logic              ldr_done,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [DATA_W-1:0] ldr_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int               CNT_W    = lat_cnt_w(RD_LAT);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LAT - 1);

    arb_state_t       state;
    arb_owner_t       owner;
    arb_owner_t       last_owner;
    logic [CNT_W-1:0] lat_cnt;
    logic [1:0]       pick;
    logic             idle_ok;

    rr_pick2 u_pick (
        .req        ({ldr_req, cpu_req}),
        .last_owner (last_owner),
        .gnt        (pick)
    );

    assign idle_ok = (state == IDLE) && !rst;
    assign cpu_gnt = cpu_req && pick[0] && idle_ok;
    assign ldr_gnt = ldr_req && pick[1] && idle_ok;

    // Strobes and done pulses are gated by rst so an abandoned access goes quiet
    // in the reset cycle itself rather than one cycle later.
    assign busy      = (state != IDLE);
    assign mem_write = (state == WRITE) && !rst;
    assign mem_read  = (state == READ) && !rst;
    assign cpu_done  = (state == RESP) && (owner == OWN_CPU) && !rst;
    assign ldr_done  = (state == RESP) && (owner == OWN_LDR) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= OWN_CPU;
            last_owner <= OWN_LDR;
            lat_cnt    <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_rdata  <= '0;
            ldr_rdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ldr_gnt) begin
                        owner      <= OWN_LDR;
                        last_owner <= OWN_LDR;
                        mem_addr   <= ldr_addr;
                        mem_wdata  <= ldr_wdata;
                        lat_cnt    <= CNT_LOAD;
                        state      <= ldr_we ? WRITE : READ;
                    end else if (cpu_gnt) begin
                        owner      <= OWN_CPU;
                        last_owner <= OWN_CPU;
                        mem_addr   <= cpu_addr;
                        mem_wdata  <= cpu_wdata;
                        lat_cnt    <= CNT_LOAD;
                        state      <= cpu_we ? WRITE : READ;
                    end
                end
                WRITE: state <= RESP;
                READ: begin
                    if (lat_cnt == '0) begin
                        if (owner == OWN_CPU) begin
                            cpu_rdata <= mem_rdata;
                        end else begin
                            ldr_rdata <= mem_rdata;
                        end
                        state <= RESP;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized
// traffic checked against a round-robin/latency model and a shadow memory.
module tb_mem_port_arbiter;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 13;
    localparam int RD_LAT = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic              cpu_req, ldr_req, cpu_we, ldr_we;
    logic [ADDR_W-1:0] cpu_addr, ldr_addr, mem_addr;
    logic [DATA_W-1:0] cpu_wdata, ldr_wdata, cpu_rdata, ldr_rdata, mem_wdata, mem_rdata;
    logic              cpu_gnt, ldr_gnt, cpu_done, ldr_done, mem_read, mem_write, busy;

    logic              cpu_req1, ldr_req1, cpu_we1, ldr_we1;
    logic [ADDR_W-1:0] cpu_addr1, ldr_addr1, mem_addr1;
    logic [DATA_W-1:0] cpu_wdata1, ldr_wdata1, cpu_rdata1, ldr_rdata1, mem_wdata1, mem_rdata1;
    logic              cpu_gnt1, ldr_gnt1, cpu_done1, ldr_done1, mem_read1, mem_write1, busy1;

    int checks = 0;
    int fails  = 0;

    logic [7:0] mem    [0:8191];
    logic [7:0] mem1   [0:8191];
    logic [7:0] shadow [0:8191];

    mem_port_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .ldr_req(ldr_req), .cpu_we(cpu_we), .ldr_we(ldr_we),
        .cpu_addr(cpu_addr), .ldr_addr(ldr_addr), .cpu_wdata(cpu_wdata), .ldr_wdata(ldr_wdata),
        .cpu_gnt(cpu_gnt), .ldr_gnt(ldr_gnt), .cpu_done(cpu_done), .ldr_done(ldr_done),
        .cpu_rdata(cpu_rdata), .ldr_rdata(ldr_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_port_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(1)) dut1 (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req1), .ldr_req(ldr_req1), .cpu_we(cpu_we1), .ldr_we(ldr_we1),
        .cpu_addr(cpu_addr1), .ldr_addr(ldr_addr1), .cpu_wdata(cpu_wdata1), .ldr_wdata(ldr_wdata1),
        .cpu_gnt(cpu_gnt1), .ldr_gnt(ldr_gnt1), .cpu_done(cpu_done1), .ldr_done(ldr_done1),
        .cpu_rdata(cpu_rdata1), .ldr_rdata(ldr_rdata1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
        .mem_read(mem_read1), .mem_write(mem_write1), .mem_rdata(mem_rdata1), .busy(busy1)
    );

    // Memory macro models: combinational read, write on the strobe edge.
    assign mem_rdata  = mem[mem_addr];
    assign mem_rdata1 = mem1[mem_addr1];
    always @(posedge clk) if (mem_write) mem[mem_addr] <= mem_wdata;
    always @(posedge clk) if (mem_write1) mem1[mem_addr1] <= mem_wdata1;

    function automatic logic [7:0] fill(input int i);
        return 8'(i * 7 + 3);
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        cpu_req = 1'b0;
        ldr_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Drives one access on a single port and records what the DUT did after acceptance.
    task automatic run_access(input bit port, input bit we, input logic [12:0] addr,
                              input logic [7:0] wdata, output int gnt_wait, output int done_at,
                              output int rd_n, output int wr_n, output int wr_at,
                              output bit addr_ok, output bit other_done, output logic [7:0] rd);
        bit granted = 1'b0;
        int n = 0;
        gnt_wait = -1; done_at = -1; rd_n = 0; wr_n = 0; wr_at = -1;
        addr_ok = 1'b1; other_done = 1'b0; rd = 'x;
        if (port == 1'b0) begin
            cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        end else begin
            ldr_req = 1'b1; ldr_we = we; ldr_addr = addr; ldr_wdata = wdata;
        end
        for (int c = 0; c < 40 && done_at < 0; c++) begin
            @(negedge clk);
            if (!granted) begin
                if (port == 1'b0 ? cpu_gnt : ldr_gnt) begin
                    granted = 1'b1;
                    gnt_wait = c;
                end
            end else begin
                n++;
                if (mem_read) rd_n++;
                if (mem_write) begin
                    wr_n++;
                    if (wr_at < 0) wr_at = n;
                end
                if ((mem_read || mem_write) && (mem_addr !== addr || (we && mem_wdata !== wdata)))
                    addr_ok = 1'b0;
                if (port == 1'b0 ? ldr_done : cpu_done) other_done = 1'b1;
                if (port == 1'b0 ? cpu_done : ldr_done) begin
                    done_at = n;
                    rd = (port == 1'b0) ? cpu_rdata : ldr_rdata;
                end
            end
            step();
            if (granted) begin
                cpu_req = 1'b0;
                ldr_req = 1'b0;
            end
        end
        cpu_req = 1'b0;
        ldr_req = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; cpu_req = 1'b1; ldr_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({cpu_gnt, ldr_gnt, cpu_done, ldr_done, mem_read, mem_write, busy} !== 7'b0)
            $display("[TB] FAIL reset_ctrl: got %b, expected 0000000",
                     {cpu_gnt, ldr_gnt, cpu_done, ldr_done, mem_read, mem_write, busy});
        step();
        rst = 1'b0; cpu_req = 1'b0; ldr_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({mem_addr, mem_wdata, cpu_rdata, ldr_rdata, busy} !== '0)
            $display("[TB] FAIL reset_regs: addr=%h wdata=%h crd=%h lrd=%h busy=%b, expected all 0",
                     mem_addr, mem_wdata, cpu_rdata, ldr_rdata, busy);
        if ({mem_addr, mem_wdata, cpu_rdata, ldr_rdata, busy} !== '0) fails++;
        step();
    endtask

    task automatic test_cpu_read;
        int gw, da, rn, wn, wa;
        bit aok, od;
        logic [7:0] rd;
        run_access(1'b0, 1'b0, 13'h010, 8'h00, gw, da, rn, wn, wa, aok, od, rd);
        checks++;
        if (gw !== 0) begin fails++; $display("[TB] FAIL cpu_read_gnt: wait=%0d, expected 0", gw); end
        checks++;
        if (rn !== RD_LAT || !aok) begin
            fails++; $display("[TB] FAIL cpu_read_strobe: reads=%0d addr_ok=%0d, expected %0d/1", rn, aok, RD_LAT);
        end
        checks++;
        if (da !== RD_LAT + 1 || rd !== 8'h5A) begin
            fails++; $display("[TB] FAIL cpu_read_done: at=%0d data=%h, expected %0d/5a", da, rd, RD_LAT + 1);
        end
        checks++;
        if (od) begin fails++; $display("[TB] FAIL cpu_read_ldr_done: got 1, expected 0"); end
    endtask

    task automatic test_ldr_write;
        int gw, da, rn, wn, wa;
        bit aok, od;
        logic [7:0] rd;
        run_access(1'b1, 1'b1, 13'h1FFF, 8'hC3, gw, da, rn, wn, wa, aok, od, rd);
        shadow[13'h1FFF] = 8'hC3;
        checks++;
        if (gw !== 0 || wn !== 1 || wa !== 1 || rn !== 0 || !aok) begin
            fails++;
            $display("[TB] FAIL ldr_write_strobe: gw=%0d writes=%0d at=%0d reads=%0d aok=%0d, expected 0/1/1/0/1",
                     gw, wn, wa, rn, aok);
        end
        checks++;
        if (da !== 2 || od) begin fails++; $display("[TB] FAIL ldr_write_done: at=%0d cpu_done=%0d, expected 2/0", da, od); end
        run_access(1'b0, 1'b0, 13'h1FFF, 8'h00, gw, da, rn, wn, wa, aok, od, rd);
        checks++;
        if (rd !== shadow[13'h1FFF]) begin
            fails++; $display("[TB] FAIL readback_1fff: got %h, expected %h", rd, shadow[13'h1FFF]);
        end
    endtask

    task automatic test_back_to_back;
        bit exp_last = 1'b1;
        bit exp_port;
        int grants = 0;
        int gcyc [4];
        bit gport [4];
        do_reset();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h020;
        ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 13'h030;
        for (int c = 0; c < 60 && grants < 4; c++) begin
            @(negedge clk);
            if (cpu_gnt && ldr_gnt) begin fails++; checks++; $display("[TB] FAIL b2b_both_gnt: cycle %0d", c); end
            if (cpu_gnt || ldr_gnt) begin
                gcyc[grants] = c;
                gport[grants] = ldr_gnt;
                grants++;
            end
            step();
        end
        cpu_req = 1'b0; ldr_req = 1'b0;
        checks++;
        if (grants !== 4) begin fails++; $display("[TB] FAIL b2b_count: got %0d grants, expected 4", grants); end
        for (int g = 0; g < grants; g++) begin
            exp_port = !exp_last;
            exp_last = exp_port;
            checks++;
            if (gport[g] !== exp_port || gcyc[g] !== g * (RD_LAT + 2)) begin
                fails++;
                $display("[TB] FAIL b2b_grant%0d: port=%0d cycle=%0d, expected port=%0d cycle=%0d",
                         g, gport[g], gcyc[g], exp_port, g * (RD_LAT + 2));
            end
        end
        repeat (RD_LAT + 2) step();
    endtask

    task automatic test_busy_ignore;
        int cpu_done_at = -1;
        int ldr_gnt_at = -1;
        int da = -1;
        logic [7:0] rd = 'x;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h040;
        @(negedge clk);
        checks++;
        if (cpu_gnt !== 1'b1) begin fails++; $display("[TB] FAIL busy_cpu_gnt: got %b, expected 1", cpu_gnt); end
        step();
        cpu_req = 1'b0; ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 13'h050;
        for (int n = 1; n <= 12 && ldr_gnt_at < 0; n++) begin
            @(negedge clk);
            if (cpu_done) cpu_done_at = n;
            if (ldr_gnt) ldr_gnt_at = n;
            step();
        end
        ldr_req = 1'b0;
        checks++;
        if (cpu_done_at !== RD_LAT + 1 || ldr_gnt_at !== RD_LAT + 2) begin
            fails++;
            $display("[TB] FAIL busy_ldr_wait: cpu_done=%0d ldr_gnt=%0d, expected %0d/%0d",
                     cpu_done_at, ldr_gnt_at, RD_LAT + 1, RD_LAT + 2);
        end
        for (int n = 1; n <= 10 && da < 0; n++) begin
            @(negedge clk);
            if (ldr_done) begin da = n; rd = ldr_rdata; end
            step();
        end
        checks++;
        if (da !== RD_LAT + 1 || rd !== shadow[13'h050]) begin
            fails++; $display("[TB] FAIL busy_ldr_read: at=%0d data=%h, expected %0d/%h", da, rd, RD_LAT + 1, shadow[13'h050]);
        end
    endtask

    task automatic test_reset_mid;
        bit stray = 1'b0;
        int gw, da, rn, wn, wa;
        bit aok, od;
        logic [7:0] rd;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h010;
        @(negedge clk);
        step();
        cpu_req = 1'b0; rst = 1'b1;
        @(negedge clk);
        checks++;
        if (mem_read !== 1'b0 || cpu_done !== 1'b0) begin
            fails++; $display("[TB] FAIL rst_mid_strobe: mem_read=%b done=%b, expected 0/0", mem_read, cpu_done);
        end
        step();
        rst = 1'b0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (cpu_done || ldr_done || mem_read || mem_write) stray = 1'b1;
            step();
        end
        checks++;
        if (stray) begin fails++; $display("[TB] FAIL rst_mid_quiet: activity seen, expected none"); end
        run_access(1'b0, 1'b0, 13'h1FFF, 8'h00, gw, da, rn, wn, wa, aok, od, rd);
        checks++;
        if (da !== RD_LAT + 1 || rd !== shadow[13'h1FFF]) begin
            fails++; $display("[TB] FAIL rst_mid_retry: at=%0d data=%h, expected %0d/%h", da, rd, RD_LAT + 1, shadow[13'h1FFF]);
        end
    endtask

    task automatic test_random;
        bit model_last = 1'b1;
        do_reset();
        for (int it = 0; it < 40; it++) begin
            int pat = $urandom_range(1, 3);
            bit c_we = 1'($urandom_range(0, 1));
            bit l_we = 1'($urandom_range(0, 1));
            logic [12:0] c_a = 13'($urandom_range(0, 31));
            logic [12:0] l_a = 13'($urandom_range(0, 31)) | (($urandom_range(0, 3) == 0) ? 13'h1FE0 : 13'h0);
            logic [7:0] c_d = 8'($urandom);
            logic [7:0] l_d = 8'($urandom);
            bit w = (pat == 3) ? !model_last : (pat == 2);
            bit w_we = w ? l_we : c_we;
            logic [12:0] w_a = w ? l_a : c_a;
            int exp_lat = w_we ? 2 : RD_LAT + 1;
            int da = -1;
            bit dport = 1'b0;
            logic [7:0] rd = 'x;
            cpu_req = pat[0]; cpu_we = c_we; cpu_addr = c_a; cpu_wdata = c_d;
            ldr_req = pat[1]; ldr_we = l_we; ldr_addr = l_a; ldr_wdata = l_d;
            @(negedge clk);
            checks++;
            if ({ldr_gnt, cpu_gnt} !== (w ? 2'b10 : 2'b01)) begin
                fails++; $display("[TB] FAIL rand%0d_gnt: got %b, expected %b", it, {ldr_gnt, cpu_gnt}, w ? 2'b10 : 2'b01);
            end
            step();
            cpu_req = 1'b0; ldr_req = 1'b0;
            for (int n = 1; n <= 10 && da < 0; n++) begin
                @(negedge clk);
                if (cpu_done || ldr_done) begin da = n; dport = ldr_done; rd = ldr_done ? ldr_rdata : cpu_rdata; end
                step();
            end
            checks++;
            if (da !== exp_lat || dport !== w) begin
                fails++; $display("[TB] FAIL rand%0d_done: at=%0d port=%0d, expected %0d/%0d", it, da, dport, exp_lat, w);
            end
            if (!w_we) begin
                checks++;
                if (rd !== shadow[w_a]) begin
                    fails++; $display("[TB] FAIL rand%0d_rdata: got %h, expected %h", it, rd, shadow[w_a]);
                end
            end else begin
                shadow[w_a] = w ? l_d : c_d;
            end
            model_last = w;
        end
    endtask

    task automatic test_rdlat1;
        cpu_req1 = 1'b1; cpu_we1 = 1'b0; cpu_addr1 = 13'h010;
        @(negedge clk);
        checks++;
        if (cpu_gnt1 !== 1'b1) begin fails++; $display("[TB] FAIL lat1_gnt: got %b, expected 1", cpu_gnt1); end
        step();
        cpu_req1 = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_read1 !== 1'b1 || cpu_done1 !== 1'b0) begin
            fails++; $display("[TB] FAIL lat1_e1: read=%b done=%b, expected 1/0", mem_read1, cpu_done1);
        end
        step();
        @(negedge clk);
        checks++;
        if (cpu_done1 !== 1'b1 || mem_read1 !== 1'b0 || cpu_rdata1 !== 8'h5A) begin
            fails++; $display("[TB] FAIL lat1_done: done=%b read=%b data=%h, expected 1/0/5a", cpu_done1, mem_read1, cpu_rdata1);
        end
        step();
        ldr_req1 = 1'b1; ldr_we1 = 1'b1; ldr_addr1 = 13'h010; ldr_wdata1 = 8'h99;
        @(negedge clk);
        step();
        ldr_req1 = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_write1 !== 1'b1 || mem_wdata1 !== 8'h99) begin
            fails++; $display("[TB] FAIL lat1_write: write=%b data=%h, expected 1/99", mem_write1, mem_wdata1);
        end
        step();
        @(negedge clk);
        checks++;
        if (ldr_done1 !== 1'b1 || cpu_rdata1 !== 8'h5A) begin
            fails++; $display("[TB] FAIL lat1_hold: ldr_done=%b cpu_rdata=%h, expected 1/5a", ldr_done1, cpu_rdata1);
        end
        step();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        for (int i = 0; i < 8192; i++) begin
            mem[i] = fill(i);
            mem1[i] = fill(i);
            shadow[i] = fill(i);
        end
        mem[16] = 8'h5A; mem1[16] = 8'h5A; shadow[16] = 8'h5A;
        rst = 1'b1;
        cpu_req = 1'b0; ldr_req = 1'b0; cpu_we = 1'b0; ldr_we = 1'b0;
        cpu_addr = '0; ldr_addr = '0; cpu_wdata = '0; ldr_wdata = '0;
        cpu_req1 = 1'b0; ldr_req1 = 1'b0; cpu_we1 = 1'b0; ldr_we1 = 1'b0;
        cpu_addr1 = '0; ldr_addr1 = '0; cpu_wdata1 = '0; ldr_wdata1 = '0;
        test_reset();
        test_cpu_read();
        test_ldr_write();
        test_back_to_back();
        test_busy_ignore();
        test_reset_mid();
        test_random();
        test_rdlat1();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
